// File: rtl/shape_commit_arbiter.sv
// Two-port write arbiter for the per-shape property registers.
// Writes from port A and port B commit only inside a bounded window that opens on each frame pulse.
//
// state | meaning
// IDLE  | window closed, no grants, waiting for frame
// OPEN  | window active, round-robin grants, cnt counts down to close
module shape_commit_arbiter #(
  parameter int MAXSHP = 4,
  parameter int IDW    = 2,
  parameter int DATAW  = 16,
  parameter int WINDOW = 64
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             frame,
  input  logic             a_valid,
  input  logic [IDW-1:0]   a_id,
  input  logic [2:0]       a_field,
  input  logic [DATAW-1:0] a_data,
  output logic             a_ready,
  input  logic             b_valid,
  input  logic [IDW-1:0]   b_id,
  input  logic [2:0]       b_field,
  input  logic [DATAW-1:0] b_data,
  output logic             b_ready,
  output logic             wr_en,
  output logic [IDW-1:0]   wr_id,
  output logic [2:0]       wr_field,
  output logic [DATAW-1:0] wr_data,
  output logic             err,
  output logic             win_open,
  output logic [7:0]       n_commits
);

  typedef enum logic {IDLE, OPEN} state_t;

  localparam logic [IDW:0] MAXSHP_W = (IDW+1)'(MAXSHP);
  localparam logic [7:0]   WIN_M1   = 8'(WINDOW - 1);

  state_t           state, state_nxt;
  logic [7:0]       cnt, cnt_nxt;
  logic             rr_b, rr_b_nxt;  // 1: port B wins the next tie
  logic             gnt_a, gnt_b;
  logic             xfer, legal;
  logic [IDW-1:0]   x_id;
  logic [2:0]       x_field;
  logic [DATAW-1:0] x_data;

  always_comb begin
    state_nxt = state;
    cnt_nxt   = cnt;
    rr_b_nxt  = rr_b;
    gnt_a     = 1'b0;
    gnt_b     = 1'b0;
    case (state)
      IDLE: begin
        if (frame) begin
          state_nxt = OPEN;
          cnt_nxt   = WIN_M1;
        end
      end
      OPEN: begin
        gnt_a = a_valid && (!b_valid || !rr_b);
        gnt_b = b_valid && (!a_valid || rr_b);
        if (gnt_a)      rr_b_nxt = 1'b1;
        else if (gnt_b) rr_b_nxt = 1'b0;
        if (cnt == 8'd0) state_nxt = IDLE;
        else             cnt_nxt   = cnt - 8'd1;
      end
      default: state_nxt = IDLE;
    endcase
  end

  assign xfer    = gnt_a | gnt_b;
  assign x_id    = gnt_b ? b_id    : a_id;
  assign x_field = gnt_b ? b_field : a_field;
  assign x_data  = gnt_b ? b_data  : a_data;
  // Illegal requests are still accepted so a requester never stalls on them.
  assign legal   = ({1'b0, x_id} < MAXSHP_W) && (x_field <= 3'd5);

  assign a_ready  = gnt_a;
  assign b_ready  = gnt_b;
  assign win_open = (state == OPEN);

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state     <= IDLE;
      cnt       <= 8'd0;
      rr_b      <= 1'b0;
      wr_en     <= 1'b0;
      wr_id     <= '0;
      wr_field  <= '0;
      wr_data   <= '0;
      err       <= 1'b0;
      n_commits <= 8'd0;
    end else begin
      state <= state_nxt;
      cnt   <= cnt_nxt;
      rr_b  <= rr_b_nxt;
      wr_en <= xfer && legal;
      err   <= xfer && !legal;
      if (xfer && legal) begin
        wr_id    <= x_id;
        wr_field <= x_field;
        wr_data  <= x_data;
      end
      if (state == IDLE && frame)
        n_commits <= 8'd0;
      else if (xfer && legal && n_commits != 8'hFF)
        n_commits <= n_commits + 8'd1;
    end
  end

endmodule
